team_06_sram_bridge: RTL and testbench

//  Downstream stage of the team_06 audio read/write controller: converts its single-cycle

---
 rtl/team_06_sram_bridge_if.sv | 21 ++
 rtl/team_06_sram_bridge.sv | 130 +++++++++++++
 tb/tb_team_06_sram_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/team_06_sram_bridge_if.sv
// Wishbone-classic master port of the team_06 SRAM bridge.
interface team_06_sram_bridge_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/team_06_sram_bridge.sv
// Converts single-cycle read/write strobes into one Wishbone-classic cycle at a time.
// Optional ACK timeout enabled by defining TEAM06_BRIDGE_TIMEOUT_EN.
module team_06_sram_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h3300_0000,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  select,
  input  logic [31:0] addressIn,
  input  logic [31:0] dataWrite,
  output logic [31:0] dataRead,
  output logic        busySRAM,
  output logic        done,
  output logic        err,
  team_06_sram_bridge_if.master wb
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : gen_bad_param
    $error("team_06_sram_bridge: DEPTH_WORDS must be a power of two >= 2, TIMEOUT_CYCLES > 0");
  end

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e      state_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        cyc_q;
  logic        done_q;
  logic [31:0] data_read_q;
  logic [31:0] req_adr;

  // Word index wraps at DEPTH_WORDS; upper request bits are intentionally dropped.
  assign req_adr = BASE_ADDR + 32'({addressIn[AW-1:0], 2'b00});

  logic unused_addr;
  assign unused_addr = ^addressIn[31:AW];

`ifdef TEAM06_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      done_q      <= 1'b0;
      data_read_q <= '0;
`ifdef TEAM06_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
`ifdef TEAM06_BRIDGE_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (write && (select != 4'h0)) begin
            adr_q   <= req_adr;
            dat_q   <= dataWrite;
            sel_q   <= select;
            we_q    <= 1'b1;
            cyc_q   <= 1'b1;
            state_q <= StBus;
          end else if (read) begin
            adr_q   <= req_adr;
            sel_q   <= 4'hF;
            we_q    <= 1'b0;
            cyc_q   <= 1'b1;
            state_q <= StBus;
          end
        end
        StBus: begin
          if (wb.wb_ack_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
            if (!we_q) data_read_q <= wb.wb_dat_i;
          end
`ifdef TEAM06_BRIDGE_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StIdle;
            if (!we_q) data_read_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_cyc_o = cyc_q;
  assign busySRAM    = cyc_q;
  assign done        = done_q;
  assign dataRead    = data_read_q;
`ifdef TEAM06_BRIDGE_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_team_06_sram_bridge.sv
// Directed plus randomized checks of team_06_sram_bridge against a transaction-level model.
module tb_team_06_sram_bridge;

  localparam logic [31:0] BASE  = 32'h3300_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  select = 4'h0;
  logic [31:0] addressIn = '0;
  logic [31:0] dataWrite = '0;
  logic [31:0] dataRead;
  logic        busySRAM;
  logic        done;
  logic        err;

  team_06_sram_bridge_if bus ();

  team_06_sram_bridge #(
    .BASE_ADDR      (BASE),
    .DEPTH_WORDS    (DEPTH),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .write     (write),
    .select    (select),
    .addressIn (addressIn),
    .dataWrite (dataWrite),
    .dataRead  (dataRead),
    .busySRAM  (busySRAM),
    .done      (done),
    .err       (err),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_dr = '0;
  logic        exp_err = 1'b0;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One request; the bench acts as the slave, acking after dly idle cycles.
  task automatic do_txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int dly, input logic [31:0] rdata,
                        input bit inject, input string tag);
    bit          is_wr;
    bit          go;
    logic [31:0] e_adr;
    int          busy_cnt;
    is_wr = wr && (s != 4'h0);
    go    = is_wr || rd;
    e_adr = BASE + (a % DEPTH) * 32'd4;
    @(negedge clk);
    write = wr; read = rd; select = s; addressIn = a; dataWrite = d;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    if (!go) begin
      chk1({tag, ".noop_cyc"}, bus.wb_cyc_o, 1'b0);
      chk1({tag, ".noop_busy"}, busySRAM, 1'b0);
      @(negedge clk);
      chk1({tag, ".noop_done"}, done, 1'b0);
      chk1({tag, ".noop_cyc2"}, bus.wb_cyc_o, 1'b0);
      return;
    end
    chk32({tag, ".adr"}, bus.wb_adr_o, e_adr);
    chk32({tag, ".sel"}, 32'(bus.wb_sel_o), is_wr ? 32'(s) : 32'hF);
    chk1({tag, ".we"}, bus.wb_we_o, is_wr);
    if (is_wr) chk32({tag, ".dat"}, bus.wb_dat_o, d);
    busy_cnt = 0;
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) @(negedge clk);
      if (busySRAM === 1'b1) busy_cnt++;
      chk1({tag, ".stb"}, bus.wb_stb_o, 1'b1);
      chk1({tag, ".cyc"}, bus.wb_cyc_o, 1'b1);
      chk1({tag, ".done_busy"}, done, 1'b0);
      chk32({tag, ".adr_hold"}, bus.wb_adr_o, e_adr);
      if (inject && i < dly) begin
        write = 1'b1; select = 4'hF; addressIn = a + 32'd3; dataWrite = ~d;
      end else begin
        write = 1'b0;
      end
      if (i == dly) begin
        bus.wb_ack_i = 1'b1;
        bus.wb_dat_i = rdata;
      end
    end
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    if (!is_wr) exp_dr = rdata;
    chk32({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(dly + 1));
    chk1({tag, ".busy_end"}, busySRAM, 1'b0);
    chk1({tag, ".cyc_end"}, bus.wb_cyc_o, 1'b0);
    chk1({tag, ".done"}, done, 1'b1);
    chk32({tag, ".dataRead"}, dataRead, exp_dr);
    chk1({tag, ".err"}, err, exp_err);
    @(negedge clk);
    chk1({tag, ".done_once"}, done, 1'b0);
    chk1({tag, ".no_requeue"}, bus.wb_cyc_o, 1'b0);
  endtask

  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst.cyc", bus.wb_cyc_o, 1'b0);
    chk1("rst.stb", bus.wb_stb_o, 1'b0);
    chk1("rst.we", bus.wb_we_o, 1'b0);
    chk32("rst.adr", bus.wb_adr_o, 32'h0);
    chk32("rst.dataRead", dataRead, 32'h0);
    chk1("rst.busy", busySRAM, 1'b0);
    chk1("rst.done", done, 1'b0);
    chk1("rst.err", err, 1'b0);
    rst = 1'b0;

    do_txn(1, 0, 32'd5, 32'hA1A2_A3A4, 4'hF, 2, 32'h0, 0, "wr5");
    do_txn(0, 1, 32'd1025, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 0, "rd1025");
    do_txn(1, 1, 32'd9, 32'h1234_5678, 4'h1, 0, 32'h5555_AAAA, 0, "wr_over_rd");
    do_txn(1, 0, 32'd9, 32'h1234_5678, 4'h0, 0, 32'h0, 0, "wr_sel0");
    do_txn(1, 0, 32'd12, 32'hCAFE_F00D, 4'hC, 4, 32'h0, 1, "wr_inject");

    // ACK while idle must not complete anything.
    @(negedge clk);
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BAD_0BAD;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk1("idle_ack.done", done, 1'b0);
    chk32("idle_ack.dataRead", dataRead, exp_dr);

    for (int k = 0; k < 40; k++) begin
      logic [3:0] s;
      int         op;
      op = int'($urandom_range(0, 3));
      s  = 4'($urandom_range(0, 15));
      do_txn(op != 1, op != 0, $urandom, $urandom, s, int'($urandom_range(0, 4)), $urandom,
             ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", k));
    end

`ifdef TEAM06_BRIDGE_TIMEOUT_EN
    begin
      int busy_cnt;
      do_txn(0, 1, 32'd2, 32'h0, 4'h0, 0, 32'h7777_1111, 0, "pre_to");
      @(negedge clk);
      read = 1'b1; addressIn = 32'd7;
      @(negedge clk);
      read = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 20 && busySRAM === 1'b1; i++) begin
        busy_cnt++;
        @(negedge clk);
      end
      exp_dr = 32'h0;
      exp_err = 1'b1;
      chk32("to.busy_cycles", 32'(busy_cnt), 32'd8);
      chk1("to.done", done, 1'b1);
      chk1("to.err", err, 1'b1);
      chk32("to.dataRead", dataRead, exp_dr);
      do_txn(0, 1, 32'd3, 32'h0, 4'h0, 1, 32'h2468_ACE0, 0, "after_to");
    end
`endif

    // Reset in the middle of a read; a late ACK must be ignored.
    @(negedge clk);
    read = 1'b1; addressIn = 32'd33;
    @(negedge clk);
    read = 1'b0;
    chk1("mid.busy_before", busySRAM, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dr = '0;
    exp_err = 1'b0;
    chk1("mid.cyc", bus.wb_cyc_o, 1'b0);
    chk1("mid.stb", bus.wb_stb_o, 1'b0);
    chk1("mid.busy", busySRAM, 1'b0);
    chk1("mid.done", done, 1'b0);
    chk1("mid.err", err, exp_err);
    chk32("mid.dataRead", dataRead, exp_dr);
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFEED_FACE;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk1("late_ack.done", done, 1'b0);
    chk1("late_ack.cyc", bus.wb_cyc_o, 1'b0);
    chk32("late_ack.dataRead", dataRead, exp_dr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
